// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with a show-ahead scancode FIFO
// and a history of the last popped bytes.
//   clk, rst      : system clock, synchronous active-high reset
//   ps2_clk/data  : raw asynchronous PS/2 pins
//   rd            : pop strobe (ignored while empty)
//   data, ready   : FIFO head (8'h00 when empty), FIFO not empty
//   count         : bytes held
//   overflow      : sticky, good frame dropped while full; cleared by a pop
//   parity_err    : one-cycle pulse, frame dropped for bad parity
//   frame_err     : one-cycle pulse, frame dropped for bad stop bit or timeout
//   key_hist      : last popped bytes, newest in [7:0]
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH  = 8,
    parameter int HIST_BYTES  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ps2_clk,
    input  logic                            ps2_data,
    input  logic                            rd,
    output logic [7:0]                      data,
    output logic                            ready,
    output logic [$clog2(FIFO_DEPTH):0]     count,
    output logic                            overflow,
    output logic                            parity_err,
    output logic                            frame_err,
    output logic [8*HIST_BYTES-1:0]         key_hist
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int HW = 8 * HIST_BYTES;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

    state_t          state_q, state_d;
    logic [1:0]      clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
    logic [2:0]      clk_samp_q, clk_samp_d, dat_samp_q, dat_samp_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            parity_err_q, parity_err_d, frame_err_q, frame_err_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [HW-1:0]   hist_q, hist_d;

    logic            fall, bit_in, push, pop, full, wr_en;
    logic [7:0]      head;

    always_comb begin
        clk_sync_d   = {clk_sync_q[0], ps2_clk};
        dat_sync_d   = {dat_sync_q[0], ps2_data};
        clk_samp_d   = {clk_samp_q[1:0], clk_sync_q[1]};
        dat_samp_d   = {dat_samp_q[1:0], dat_sync_q[1]};
        // [2] is the oldest stage; data is taken from the stage of the same
        // age as the first low clock sample.
        fall         = (clk_samp_q == 3'b100);
        bit_in       = dat_samp_q[1];

        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        tmo_d        = tmo_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        push         = 1'b0;

        if (state_q != ST_IDLE) begin
            tmo_d = tmo_q + 1'b1;
        end

        if (fall) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!bit_in) begin
                        state_d  = ST_DATA;
                        bitcnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d  = {bit_in, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_d   = bit_in;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (!(^{shift_q, par_q})) parity_err_d = 1'b1;
                    else if (!bit_in)         frame_err_d  = 1'b1;
                    else                      push         = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d     = ST_IDLE;
            tmo_d       = '0;
            frame_err_d = 1'b1;
        end
    end

    always_comb begin
        head       = mem_q[rd_ptr_q];
        full       = (count_q == CW'(FIFO_DEPTH));
        pop        = rd && (count_q != '0);
        // A push into a full FIFO succeeds when the same cycle frees a slot.
        wr_en      = push && (!full || pop);
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        hist_d     = hist_q;

        if (pop) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            hist_d     = hist_q << 8;
            hist_d[7:0] = head;
            overflow_d = 1'b0;
        end
        if (wr_en) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (push && !wr_en) overflow_d = 1'b1;

        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            clk_sync_q   <= '1;
            dat_sync_q   <= '1;
            clk_samp_q   <= '1;
            dat_samp_q   <= '1;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            hist_q       <= '0;
        end else begin
            state_q      <= state_d;
            clk_sync_q   <= clk_sync_d;
            dat_sync_q   <= dat_sync_d;
            clk_samp_q   <= clk_samp_d;
            dat_samp_q   <= dat_samp_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            tmo_q        <= tmo_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            hist_q       <= hist_d;
        end
    end

    assign data       = (count_q == '0) ? 8'h00 : head;
    assign ready      = (count_q != '0);
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign key_hist   = hist_q;
endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, scancode FIFO entries; power of two, 2..64.
REQ-002 Parameter HIST_BYTES, default 4, depth of the popped-byte history register, 1..8.
REQ-003 Parameter TIMEOUT_CYC, default 50000, clk cycles without a PS/2 falling edge before a partial frame is abandoned.
REQ-004 clk  input  1  system clock; single clock domain; all state changes on rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 ps2_clk  input  1  raw PS/2 clock pin, asynchronous.
REQ-007 ps2_data  input  1  raw PS/2 data pin, asynchronous.
REQ-008 rd  input  1  pop strobe, one cycle per byte.
REQ-009 data  output  8  FIFO head byte (show-ahead); 8'h00 when empty.
REQ-010 ready  output  1  FIFO not empty.
REQ-011 count  output  clog2(FIFO_DEPTH)+1  bytes held.
REQ-012 overflow  output  1  sticky: a good frame was dropped because FIFO full.
REQ-013 parity_err  output  1  one-cycle pulse: frame discarded for parity error.
REQ-014 frame_err  output  1  one-cycle pulse: frame discarded for bad stop bit or timeout.
REQ-015 key_hist  output  8*HIST_BYTES  last popped bytes, newest in [7:0].

Function
REQ-016 ps2_clk and ps2_data SHALL pass a 2-FF synchronizer, then a 3-stage sample shift; a falling-edge event SHALL be one cycle when the three stages read oldest-to-newest 1,0,0.
REQ-017 Receiver FSM states SHALL be IDLE, DATA, PARITY, STOP; all transitions occur only on falling-edge events or timeout.
REQ-018 IDLE: edge with data=0 -> DATA, bit counter=0; edge with data=1 -> stay IDLE, no error.
REQ-019 DATA: each edge shifts data in LSB first; after the 8th bit -> PARITY.
REQ-020 PARITY: edge samples parity bit -> STOP; odd parity over 8 data bits + parity bit required.
REQ-021 STOP: edge -> IDLE; stop=1 and parity good -> push byte; parity bad -> parity_err pulse, no push; stop=0 with parity good -> frame_err pulse, no push; both bad -> parity_err only.
REQ-022 Push SHALL occur in the STOP-edge cycle; ready/count/data SHALL reflect it on the next cycle.
REQ-023 In any state but IDLE, TIMEOUT_CYC cycles without an edge SHALL force IDLE, discard the partial byte, pulse frame_err once.
REQ-024 rd with ready=1 SHALL pop the head; head, count, ready update next cycle; rd with ready=0 ignored.
REQ-025 On pop, key_hist SHALL shift left by 8 and take the popped byte in [7:0].
REQ-026 Push while full and no pop: byte dropped, overflow set; contents unchanged.
REQ-027 Push and pop in the same cycle: both succeed, count unchanged, no overflow, including when full.
REQ-028 overflow SHALL clear on the first successful pop after being set, unless the same cycle also sets it.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH; count distinguishes full from empty.

Reset
REQ-030 rst=1 on a rising edge SHALL set FSM IDLE, pointers/count 0, data 8'h00, ready 0, overflow 0, parity_err 0, frame_err 0, key_hist 0, timeout counter 0, synchronizer and sample stages all 1.
REQ-031 rst mid-frame SHALL discard the partial frame with no error pulse; the next start bit is received normally.
REQ-032 rst SHALL dominate simultaneous push/pop in the same cycle.

Verification
REQ-033 Send frame 0x1C with odd parity 0, stop 1 -> ready=1, data=0x1C, count=1; rd -> ready=0, key_hist[7:0]=0x1C.
REQ-034 Send 0xF0 then 0x1C, pop both -> data order F0, 1C; key_hist[15:0]=16'hF01C.
REQ-035 Send 0x1C with parity bit 1 -> parity_err one-cycle pulse, ready stays 0, count 0.
REQ-036 FIFO_DEPTH=8: send 9 frames 0x01..0x09 without rd -> count=8, overflow=1, pops return 0x01..0x08; overflow clears after first pop.
REQ-037 Stop after 4 data bits, idle TIMEOUT_CYC+2 cycles -> one frame_err pulse, FSM IDLE; following full frame 0x5A received correctly.
REQ-038 FIFO full, assert rd in the STOP-edge cycle of a new frame -> count stays 8, overflow stays 0, new byte at tail.
